io_dma_mst: RTL and testbench
=============================

IO_DMA_MST -- requirements
Module: io_dma_mst

Interface
REQ-001 SHALL have parameter AW, default 14, meaning IO word-address width (byte addr bits [15:2]).
REQ-002 SHALL have parameter LW, default 8, meaning transfer-length field width in words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  engine idle; command accepted when cmd_valid & cmd_ready.
REQ-007 SHALL have ports cmd_src / cmd_dst  input  AW  source / destination word address.
REQ-008 SHALL have port cmd_len  input  LW  word count; 0 = no-op.
REQ-009 SHALL have ports cmd_fix_src / cmd_fix_dst  input  1  hold address constant (FIFO-style register).
REQ-010 SHALL have port abort  input  1  cancel active transfer.
REQ-011 SHALL have port io_gnt  input  1  bus granted to this master this cycle.
REQ-012 SHALL have ports busy / done / aborted  output  1  active / one-cycle completion pulse / one-cycle abort pulse.
REQ-013 SHALL have ports dma_io_we  output  1, dma_io_wadr  output  AW, dma_io_wdata  output  32, write strobe/address/data.
REQ-014 SHALL have ports dma_io_radr_en  output  1, dma_io_radr  output  AW, read strobe/address.
REQ-015 SHALL have port dma_io_rdata  input  32  read data, valid the cycle after dma_io_radr_en.

Function
REQ-016 SHALL implement FSM states IDLE, RD, CAP, WR, FIN.
REQ-017 SHALL in IDLE assert cmd_ready; on accept latch src, dst, len, fix flags; len!=0 -> RD, len==0 -> FIN.
REQ-018 SHALL in RD drive radr_en=io_gnt, radr=cur_src; advance to CAP only in a cycle with io_gnt=1.
REQ-019 SHALL in CAP latch dma_io_rdata into data register; always -> WR (one cycle).
REQ-020 SHALL in WR drive we=io_gnt, wadr=cur_dst, wdata=data register; advance only when io_gnt=1.
REQ-021 SHALL on granted WR: decrement remaining count; cur_src+=1 unless fix_src; cur_dst+=1 unless fix_dst; remaining==1 -> FIN else RD.
REQ-022 SHALL in FIN pulse done for exactly one cycle, then IDLE.
REQ-023 SHALL wrap address increments modulo 2^AW (0x3FFF+1 -> 0x0000), no error.
REQ-024 SHALL drive we, radr_en low and wadr, radr, wdata to zero whenever not strobing.
REQ-025 SHALL, on abort=1 in RD/CAP/WR, go to IDLE next cycle and pulse aborted one cycle; done not pulsed; a strobe decoded in the abort cycle still occurs.
REQ-026 SHALL ignore abort in IDLE and FIN (FIN completes with done).
REQ-027 SHALL assert busy in every state except IDLE; cmd_ready = ~busy.
REQ-028 SHALL need exactly 3 cycles per word with io_gnt held high; latency accept->done = 3*len+1 cycles.
REQ-029 SHALL never assert dma_io_we and dma_io_radr_en in the same cycle.

Reset
REQ-030 SHALL on rst_n=0 immediately force IDLE; cmd_ready=1; busy, done, aborted, we, radr_en=0; all addresses, count, data=0; mid-transfer reset discards transfer with no pulse.

Structure
REQ-031 SHALL place state encoding and AW/LW defaults in shared package io_dma_pkg.
REQ-032 SHALL be a single module; no sub-module.

Verification
REQ-033 SHALL test: src=0x0100,dst=0x0200,len=4,gnt=1 -> reads 0x0100..0x0103, writes 0x0200..0x0203 with data, done at cycle 13.
REQ-034 SHALL test: len=0 -> no strobes, done one cycle after accept, cmd_ready back next cycle.
REQ-035 SHALL test: src=0x3FFE,len=3,fix_dst=1,dst=0x3E00 -> reads 0x3FFE,0x3FFF,0x0000; all writes to 0x3E00.
REQ-036 SHALL test: io_gnt low 5 cycles during RD -> no strobes, state held, data still correct after regrant.
REQ-037 SHALL test: abort in CAP of word 2 of len=4 -> 1 write only, aborted pulse, no done, new command accepted next cycle.
REQ-038 SHALL test: rst_n low during WR -> strobes drop asynchronously, cmd_ready=1 after release.

Source files
------------

// File: rtl/io_dma_pkg.sv
// Shared definitions for the IO DMA master: default widths and FSM state encoding.
package io_dma_pkg;

  localparam int IO_DMA_AW = 14;  // IO word-address width (byte address bits [15:2])
  localparam int IO_DMA_LW = 8;   // transfer-length field width, in words

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } dma_state_t;

endpackage

// File: rtl/io_dma_mst.sv
// IO DMA master: copies cmd_len words from a source to a destination IO address,
// one word at a time (read, capture, write), arbitrated by io_gnt.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// RD    | read strobe for cur_src, held until io_gnt
// CAP   | read data returns; latch into data register
// WR    | write strobe of data register to cur_dst, held until io_gnt
// FIN   | one-cycle done pulse, then back to IDLE
module io_dma_mst
  import io_dma_pkg::*;
#(
  parameter int AW = IO_DMA_AW,
  parameter int LW = IO_DMA_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  input  logic [LW-1:0] cmd_len,
  input  logic          cmd_fix_src,
  input  logic          cmd_fix_dst,
  input  logic          abort,
  input  logic          io_gnt,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          dma_io_we,
  output logic [AW-1:0] dma_io_wadr,
  output logic [31:0]   dma_io_wdata,
  output logic          dma_io_radr_en,
  output logic [AW-1:0] dma_io_radr,
  input  logic [31:0]   dma_io_rdata
);

  dma_state_t    state_q, state_d;
  logic [AW-1:0] cur_src_q, cur_dst_q;
  logic [LW-1:0] remaining_q;
  logic          fix_src_q, fix_dst_q;
  logic [31:0]   data_q;
  logic          aborted_q;
  logic          in_xfer;

  assign in_xfer   = (state_q == ST_RD) || (state_q == ST_CAP) || (state_q == ST_WR);
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign done      = (state_q == ST_FIN);
  assign aborted   = aborted_q;

  // State register; reset discards any transfer in flight without a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and bus strobes; address/data buses are zero unless strobing.
  always_comb begin
    state_d        = state_q;
    dma_io_radr_en = 1'b0;
    dma_io_radr    = '0;
    dma_io_we      = 1'b0;
    dma_io_wadr    = '0;
    dma_io_wdata   = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) state_d = (cmd_len != '0) ? ST_RD : ST_FIN;
      end
      ST_RD: begin
        if (io_gnt) begin
          dma_io_radr_en = 1'b1;
          dma_io_radr    = cur_src_q;
          state_d        = ST_CAP;
        end
        if (abort) state_d = ST_IDLE;
      end
      ST_CAP: begin
        state_d = abort ? ST_IDLE : ST_WR;
      end
      ST_WR: begin
        if (io_gnt) begin
          dma_io_we    = 1'b1;
          dma_io_wadr  = cur_dst_q;
          dma_io_wdata = data_q;
          state_d      = (remaining_q == LW'(1)) ? ST_FIN : ST_RD;
        end
        if (abort) state_d = ST_IDLE;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Transfer context: latched on accept, advanced after each granted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_src_q   <= '0;
      cur_dst_q   <= '0;
      remaining_q <= '0;
      fix_src_q   <= 1'b0;
      fix_dst_q   <= 1'b0;
      data_q      <= '0;
      aborted_q   <= 1'b0;
    end else begin
      aborted_q <= abort && in_xfer;
      if (state_q == ST_IDLE && cmd_valid) begin
        cur_src_q   <= cmd_src;
        cur_dst_q   <= cmd_dst;
        remaining_q <= cmd_len;
        fix_src_q   <= cmd_fix_src;
        fix_dst_q   <= cmd_fix_dst;
      end
      if (state_q == ST_CAP) data_q <= dma_io_rdata;
      if (state_q == ST_WR && io_gnt) begin
        remaining_q <= remaining_q - LW'(1);
        if (!fix_src_q) cur_src_q <= cur_src_q + AW'(1);  // wraps modulo 2^AW
        if (!fix_dst_q) cur_dst_q <= cur_dst_q + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_io_dma_mst.sv
// Scoreboard bench for io_dma_mst: a word-level copy model predicts the read
// addresses, write address/data pairs and completion events of each command.
module tb_io_dma_mst;

  localparam int AW = 14;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_src, cmd_dst;
  logic [LW-1:0] cmd_len;
  logic          cmd_fix_src, cmd_fix_dst;
  logic          abort, io_gnt;
  logic          busy, done, aborted;
  logic          dma_io_we, dma_io_radr_en;
  logic [AW-1:0] dma_io_wadr, dma_io_radr;
  logic [31:0]   dma_io_wdata;
  logic [31:0]   dma_io_rdata = 32'h0;

  io_dma_mst #(.AW(AW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_fix_src(cmd_fix_src), .cmd_fix_dst(cmd_fix_dst),
    .abort(abort), .io_gnt(io_gnt),
    .busy(busy), .done(done), .aborted(aborted),
    .dma_io_we(dma_io_we), .dma_io_wadr(dma_io_wadr), .dma_io_wdata(dma_io_wdata),
    .dma_io_radr_en(dma_io_radr_en), .dma_io_radr(dma_io_radr),
    .dma_io_rdata(dma_io_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] adr; logic [31:0] dat; } wr_t;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] exp_rd[$];
  wr_t           exp_wr[$];
  int            exp_evt[$];   // 1 = done, 2 = aborted
  int            checks = 0;
  int            failures = 0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  bit            gnt_rand = 0;

  // IO slave: read data returns the cycle after the read strobe.
  always @(posedge clk) begin
    if (dma_io_radr_en) dma_io_rdata <= mem[dma_io_radr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: word i of a copy reads src+i and writes dst+i (mod 2^AW)
  // unless the side is fixed. Only the first n_rd reads / n_wr writes happen.
  task automatic model(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n_rd,
                       input int n_wr, input bit fs, input bit fd, input int evt);
    wr_t w;
    for (int i = 0; i < n_rd; i++)
      exp_rd.push_back(fs ? s : AW'((int'(s) + i) % (1 << AW)));
    for (int i = 0; i < n_wr; i++) begin
      logic [AW-1:0] sa;
      sa = fs ? s : AW'((int'(s) + i) % (1 << AW));
      w.adr = fd ? d : AW'((int'(d) + i) % (1 << AW));
      w.dat = mem[sa];
      exp_wr.push_back(w);
    end
    if (evt != 0) exp_evt.push_back(evt);
  endtask

  // Monitor: compare every strobe and every completion pulse against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dma_io_radr_en) begin
        rd_cnt++;
        chk("rd_we_exclusive", {31'h0, dma_io_we}, 32'h0);
        if (exp_rd.size() == 0) chk("unexpected_read", {18'h0, dma_io_radr}, 32'hFFFFFFFF);
        else chk("read_addr", {18'h0, dma_io_radr}, {18'h0, exp_rd.pop_front()});
      end else begin
        chk("radr_idle_zero", {18'h0, dma_io_radr}, 32'h0);
      end
      if (dma_io_we) begin
        wr_t w;
        wr_cnt++;
        if (exp_wr.size() == 0) chk("unexpected_write", {18'h0, dma_io_wadr}, 32'hFFFFFFFF);
        else begin
          w = exp_wr.pop_front();
          chk("write_addr", {18'h0, dma_io_wadr}, {18'h0, w.adr});
          chk("write_data", dma_io_wdata, w.dat);
        end
      end else begin
        chk("wadr_idle_zero", {18'h0, dma_io_wadr}, 32'h0);
        chk("wdata_idle_zero", dma_io_wdata, 32'h0);
      end
      if (done || aborted) begin
        if (exp_evt.size() == 0) chk("unexpected_event", {30'h0, aborted, done}, 32'h0);
        else chk("event_kind", done ? 32'd1 : (aborted ? 32'd2 : 32'd0), exp_evt.pop_front());
        chk("done_abort_exclusive", {31'h0, done & aborted}, 32'h0);
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l,
                       input bit fs, input bit fd);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1; n++;
      if (gnt_rand) io_gnt = ($urandom_range(0, 3) != 0);
    end
    if (!cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
    cmd_src = s; cmd_dst = d; cmd_len = l; cmd_fix_src = fs; cmd_fix_dst = fd;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    if (gnt_rand) io_gnt = ($urandom_range(0, 3) != 0);
    cmd_valid = 1'b0;
    cmd_src = $urandom; cmd_dst = $urandom; cmd_len = $urandom;
  endtask

  // Count cycles (accept cycle = 0) until done or aborted; what: 1 done, 2 aborted.
  task automatic wait_end(input int start, output int cyc, output int what);
    cyc = start;
    what = 0;
    while (cyc < 3000) begin
      if (done) what = 1;
      else if (aborted) what = 2;
      if (what != 0) break;
      @(posedge clk); #1; cyc++;
      if (gnt_rand) io_gnt = ($urandom_range(0, 3) != 0);
    end
    if (what == 0) chk("end_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc, what, r0, w0;
    logic [AW-1:0] s, d;
    logic [LW-1:0] l;
    bit fs, fd;

    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    cmd_fix_src = 1'b0; cmd_fix_dst = 1'b0; abort = 1'b0; io_gnt = 1'b1;
    #2;
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_aborted", {31'h0, aborted}, 32'd0);
    chk("rst_strobes", {30'h0, dma_io_we, dma_io_radr_en}, 32'd0);
    chk("rst_buses", {18'h0, dma_io_wadr | dma_io_radr} | dma_io_wdata, 32'd0);
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic 4-word copy with permanent grant.
    model(14'h0100, 14'h0200, 4, 4, 1'b0, 1'b0, 1);
    issue(14'h0100, 14'h0200, 8'd4, 1'b0, 1'b0);
    wait_end(1, cyc, what);
    chk("basic_latency", cyc, 32'd13);
    chk("basic_done", what, 32'd1);
    @(posedge clk); #1;
    chk("basic_ready_after", {31'h0, cmd_ready}, 32'd1);

    // Zero-length command.
    r0 = rd_cnt; w0 = wr_cnt;
    model(14'h0010, 14'h0020, 0, 0, 1'b0, 1'b0, 1);
    issue(14'h0010, 14'h0020, 8'd0, 1'b0, 1'b0);
    wait_end(1, cyc, what);
    chk("len0_latency", cyc, 32'd1);
    @(posedge clk); #1;
    chk("len0_ready_back", {31'h0, cmd_ready}, 32'd1);
    chk("len0_no_strobes", rd_cnt + wr_cnt - r0 - w0, 32'd0);

    // Source wrap with fixed destination.
    model(14'h3FFE, 14'h3E00, 3, 3, 1'b0, 1'b1, 1);
    issue(14'h3FFE, 14'h3E00, 8'd3, 1'b0, 1'b1);
    wait_end(1, cyc, what);
    chk("wrap_latency", cyc, 32'd10);

    // Grant withheld for 5 cycles in RD.
    @(posedge clk); #1;
    io_gnt = 1'b0;
    r0 = rd_cnt;
    model(14'h1234, 14'h2345, 2, 2, 1'b0, 1'b0, 1);
    issue(14'h1234, 14'h2345, 8'd2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("nognt_busy", {31'h0, busy}, 32'd1);
      chk("nognt_strobes", {30'h0, dma_io_we, dma_io_radr_en}, 32'd0);
      @(posedge clk); #1;
    end
    chk("nognt_no_reads", rd_cnt - r0, 32'd0);
    io_gnt = 1'b1;
    wait_end(6, cyc, what);
    chk("nognt_latency", cyc, 32'd12);

    // Abort in CAP of word 2 of a 4-word copy.
    @(posedge clk); #1;
    w0 = wr_cnt;
    model(14'h0500, 14'h0600, 2, 1, 1'b0, 1'b0, 2);
    issue(14'h0500, 14'h0600, 8'd4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_pulse", {31'h0, aborted}, 32'd1);
    chk("abort_no_done", {31'h0, done}, 32'd0);
    chk("abort_ready", {31'h0, cmd_ready}, 32'd1);
    chk("abort_one_write", wr_cnt - w0, 32'd1);
    model(14'h0700, 14'h0800, 1, 1, 1'b0, 1'b0, 1);
    issue(14'h0700, 14'h0800, 8'd1, 1'b0, 1'b0);
    chk("abort_next_accepted", {31'h0, busy}, 32'd1);
    chk("abort_pulse_one_cycle", {31'h0, aborted}, 32'd0);
    wait_end(1, cyc, what);
    chk("post_abort_latency", cyc, 32'd4);

    // Reset asserted during WR of the first word.
    @(posedge clk); #1;
    model(14'h0900, 14'h0A00, 1, 0, 1'b0, 1'b0, 0);
    issue(14'h0900, 14'h0A00, 8'd3, 1'b0, 1'b0);
    @(posedge clk); #1; @(posedge clk); #1;
    chk("wr_before_reset", {31'h0, dma_io_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_we_drop", {31'h0, dma_io_we}, 32'd0);
    chk("reset_wadr_zero", {18'h0, dma_io_wadr}, 32'd0);
    chk("reset_busy", {31'h0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready_after", {31'h0, cmd_ready}, 32'd1);
    chk("reset_no_done", {31'h0, done | aborted}, 32'd0);

    // Randomized commands with random grant.
    gnt_rand = 1;
    for (int n = 0; n < 20; n++) begin
      s = ($urandom_range(0, 3) == 0) ? AW'(14'h3FFC + $urandom_range(0, 3)) : AW'($urandom);
      d = AW'($urandom);
      l = LW'($urandom_range(0, 6));
      fs = ($urandom_range(0, 3) == 0);
      fd = ($urandom_range(0, 3) == 0);
      model(s, d, int'(l), int'(l), fs, fd, 1);
      issue(s, d, l, fs, fd);
      wait_end(1, cyc, what);
      chk("rand_done", what, 32'd1);
    end
    gnt_rand = 0;
    io_gnt = 1'b1;

    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    chk("left_reads", exp_rd.size(), 32'd0);
    chk("left_writes", exp_wr.size(), 32'd0);
    chk("left_events", exp_evt.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
